andn_seq_ctrl: RTL

Sequencer that computes the AND-reduction of a wide operand over multiple cycles. It time-shares one CHUNK-wide AND-reduction datapath across the WIDTH-bit operand.
Valid/ready on both the input side and the result side.
Terminates early on the first chunk containing a zero.
Reports how many chunks were evaluated. Used where a full-width combinational AND chain would break timing.

---
 rtl/andn_seq_pkg.sv | 21 ++
 rtl/andn_seq_ctrl_and_chunk.sv | 21 ++
 rtl/andn_seq_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/andn_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle AND-reduction sequencer.
package andn_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Width needed to hold a chunk count in the range 0..nchunk.
    function automatic int cnt_width(input int nchunk);
        return $clog2(nchunk + 1);
    endfunction

    // Width of the chunk index; kept at one bit or more so a single-chunk
    // configuration still has a real register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/andn_seq_ctrl_and_chunk.sv
// Combinational N-input AND reduction, built as an explicit ripple chain so
// the depth of the shared slice datapath is visible in the netlist.
module and_chunk #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    output logic         y
);

    for (genvar i = 0; i < N; i++) begin : g_stage
        logic acc_s;
        if (i == 0) begin : g_first
            assign acc_s = a[0];
        end else begin : g_next
            assign acc_s = g_stage[i-1].acc_s & a[i];
        end
    end

    assign y = g_stage[N-1].acc_s;

endmodule

// File: rtl/andn_seq_ctrl.sv
// Multi-cycle AND-reduction sequencer: accepts a WIDTH-bit operand, reduces
// it CHUNK bits per cycle through one shared AND datapath, stops at the first
// chunk that contains a zero and reports the result plus the chunk count.
module andn_seq_ctrl
    import andn_seq_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1,
    localparam int CW     = cnt_width(NCHUNK)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic [CW-1:0]    out_cycles,
    output logic             busy
);

    localparam int IW = idx_width(NCHUNK);

    // Reject configurations that cannot be split into whole chunks.
    if (CHUNK < 1) begin : g_bad_chunk
        $fatal(1, "andn_seq_ctrl: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $fatal(1, "andn_seq_ctrl: WIDTH must be a multiple of CHUNK");
    end

    state_t            state_r, state_next_s;
    logic [IW-1:0]     idx_r, idx_next_s;
    logic [WIDTH-1:0]  operand_r, operand_next_s;
    logic              out_y_r, out_y_next_s;
    logic [CW-1:0]     out_cycles_r, out_cycles_next_s;
    logic              out_valid_r;
    logic              busy_r;
    logic [CHUNK-1:0]  chunk_s;
    logic              chunk_and_s;

    // Select the chunk addressed by the index with an AND-OR mux.
    always_comb begin
        chunk_s = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            chunk_s = chunk_s
                    | (operand_r[k*CHUNK +: CHUNK] & {CHUNK{idx_r == IW'(k)}});
        end
    end

    and_chunk #(
        .N (CHUNK)
    ) u_and_chunk (
        .a (chunk_s),
        .y (chunk_and_s)
    );

    // Next-state and next-datapath decode for the sequencer.
    always_comb begin
        state_next_s      = state_r;
        idx_next_s        = idx_r;
        operand_next_s    = operand_r;
        out_y_next_s      = out_y_r;
        out_cycles_next_s = out_cycles_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    operand_next_s = in_data;
                    idx_next_s     = '0;
                    state_next_s   = S_EVAL;
                end else begin
                    state_next_s   = S_IDLE;
                end
            end
            S_EVAL: begin
                if (!chunk_and_s) begin
                    out_y_next_s      = 1'b0;
                    out_cycles_next_s = CW'(idx_r) + CW'(1'b1);
                    state_next_s      = S_DONE;
                end else if (idx_r == IW'(NCHUNK - 1)) begin
                    out_y_next_s      = 1'b1;
                    out_cycles_next_s = CW'(NCHUNK);
                    state_next_s      = S_DONE;
                end else begin
                    idx_next_s        = idx_r + IW'(1'b1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            idx_r        <= '0;
            operand_r    <= '0;
            out_y_r      <= 1'b0;
            out_cycles_r <= '0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            idx_r        <= idx_next_s;
            operand_r    <= operand_next_s;
            out_y_r      <= out_y_next_s;
            out_cycles_r <= out_cycles_next_s;
            out_valid_r  <= (state_next_s == S_DONE);
            busy_r       <= (state_next_s != S_IDLE);
        end
    end

    // Ready depends only on the state so it never loops back from in_valid.
    assign in_ready   = (state_r == S_IDLE) && reset_n;
    assign out_valid  = out_valid_r;
    assign out_y      = out_y_r;
    assign out_cycles = out_cycles_r;
    assign busy       = busy_r;

endmodule
